// File: rtl/piece_move_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | piece_move_ctrl_if : request, calculator, board and state bundle     |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface piece_move_ctrl_if #(
  parameter int BITS_PER_BLOCK = 3
);
  logic                      req_valid;
  logic [2:0]                req_op;
  logic [BITS_PER_BLOCK-1:0] req_piece;
  logic                      req_ready;

  logic [BITS_PER_BLOCK-1:0] calc_piece;
  logic [3:0]                calc_x;
  logic [4:0]                calc_y;
  logic [1:0]                calc_rot;
  logic [7:0]                calc_blk_1;
  logic [7:0]                calc_blk_2;
  logic [7:0]                calc_blk_3;
  logic [7:0]                calc_blk_4;
  logic [2:0]                calc_width;
  logic [2:0]                calc_height;

  logic [7:0]                board_rd_addr;
  logic                      board_rd_data;

  logic [BITS_PER_BLOCK-1:0] cur_piece;
  logic [3:0]                cur_x;
  logic [4:0]                cur_y;
  logic [1:0]                cur_rot;
  logic                      done;
  logic                      ok;
  logic                      landed;
  logic                      game_over;

  // Environment side: requester, calculator, board memory and consumers
  modport master (
    output req_valid, req_op, req_piece,
    input  req_ready,
    input  calc_piece, calc_x, calc_y, calc_rot,
    output calc_blk_1, calc_blk_2, calc_blk_3, calc_blk_4, calc_width, calc_height,
    input  board_rd_addr,
    output board_rd_data,
    input  cur_piece, cur_x, cur_y, cur_rot, done, ok, landed, game_over
  );

  modport slave (
    input  req_valid, req_op, req_piece,
    output req_ready,
    output calc_piece, calc_x, calc_y, calc_rot,
    input  calc_blk_1, calc_blk_2, calc_blk_3, calc_blk_4, calc_width, calc_height,
    output board_rd_addr,
    input  board_rd_data,
    output cur_piece, cur_x, cur_y, cur_rot, done, ok, landed, game_over
  );
endinterface
`default_nettype wire

// File: rtl/piece_move_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | piece_move_ctrl : validates and commits falling-piece move requests  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module piece_move_ctrl #(
  parameter int                        BLOCKS_WIDE    = 10,
  parameter int                        BLOCKS_HIGH    = 20,
  parameter int                        SPAWN_X        = 4,
  parameter int                        BITS_PER_BLOCK = 3,
  parameter logic [BITS_PER_BLOCK-1:0] EMPTY_BLOCK    = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  piece_move_ctrl_if.slave   bus
);

  localparam logic [2:0] c_op_left  = 3'd0;
  localparam logic [2:0] c_op_right = 3'd1;
  localparam logic [2:0] c_op_rot   = 3'd2;
  localparam logic [2:0] c_op_down  = 3'd3;
  localparam logic [2:0] c_op_spawn = 3'd4;
  localparam logic [4:0] c_wide     = 5'(BLOCKS_WIDE);
  localparam logic [5:0] c_high     = 6'(BLOCKS_HIGH);
  localparam logic [3:0] c_spawn_x  = 4'(SPAWN_X);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BOUND = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                    r_state, w_state_nxt;
  logic [2:0]                r_op, w_op_nxt;
  logic [BITS_PER_BLOCK-1:0] r_cand_piece, w_cand_piece_nxt;
  logic [3:0]                r_cand_x, w_cand_x_nxt;
  logic [4:0]                r_cand_y, w_cand_y_nxt;
  logic [1:0]                r_cand_rot, w_cand_rot_nxt;
  logic [2:0]                r_k, w_k_nxt;
  logic                      r_occ, w_occ_nxt;
  logic                      r_ok, w_ok_nxt;
  logic [BITS_PER_BLOCK-1:0] r_cur_piece, w_cur_piece_nxt;
  logic [3:0]                r_cur_x, w_cur_x_nxt;
  logic [4:0]                r_cur_y, w_cur_y_nxt;
  logic [1:0]                r_cur_rot, w_cur_rot_nxt;

  logic [7:0] w_rd_addr;
  logic       w_req_ready, w_done, w_landed, w_game_over;
  logic       w_imm_rej, w_fin, w_fin_ok;
  logic [4:0] w_x_sum;
  logic [5:0] w_y_sum;
  logic       w_occ_acc;

  // Sums widened so an out-of-range candidate can never wrap back in range
  assign w_x_sum   = {1'b0, r_cand_x} + {2'b00, bus.calc_width};
  assign w_y_sum   = {1'b0, r_cand_y} + {3'b000, bus.calc_height};
  assign w_occ_acc = r_occ | bus.board_rd_data;

  always_comb begin
    w_state_nxt      = r_state;
    w_op_nxt         = r_op;
    w_cand_piece_nxt = r_cand_piece;
    w_cand_x_nxt     = r_cand_x;
    w_cand_y_nxt     = r_cand_y;
    w_cand_rot_nxt   = r_cand_rot;
    w_k_nxt          = r_k;
    w_occ_nxt        = r_occ;
    w_ok_nxt         = r_ok;
    w_cur_piece_nxt  = r_cur_piece;
    w_cur_x_nxt      = r_cur_x;
    w_cur_y_nxt      = r_cur_y;
    w_cur_rot_nxt    = r_cur_rot;
    w_rd_addr        = '0;
    w_req_ready      = 1'b0;
    w_done           = 1'b0;
    w_landed         = 1'b0;
    w_game_over      = 1'b0;
    w_imm_rej        = 1'b0;
    w_fin            = 1'b0;
    w_fin_ok         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) begin
          w_op_nxt         = bus.req_op;
          w_k_nxt          = 3'd1;
          w_occ_nxt        = 1'b0;
          w_cand_piece_nxt = r_cur_piece;
          w_cand_x_nxt     = r_cur_x;
          w_cand_y_nxt     = r_cur_y;
          w_cand_rot_nxt   = r_cur_rot;
          case (bus.req_op)
            c_op_left:  w_cand_x_nxt   = r_cur_x - 4'd1;
            c_op_right: w_cand_x_nxt   = r_cur_x + 4'd1;
            c_op_rot:   w_cand_rot_nxt = r_cur_rot + 2'd1;
            c_op_down:  w_cand_y_nxt   = r_cur_y + 5'd1;
            c_op_spawn: begin
              w_cand_piece_nxt = bus.req_piece;
              w_cand_x_nxt     = c_spawn_x;
              w_cand_y_nxt     = '0;
              w_cand_rot_nxt   = '0;
            end
            default: ;
          endcase
          w_imm_rej = (bus.req_op > c_op_spawn) ||
                      ((bus.req_op != c_op_spawn) && (r_cur_piece == EMPTY_BLOCK)) ||
                      ((bus.req_op == c_op_left) && (r_cur_x == 4'd0));
          if (w_imm_rej) begin
            w_fin       = 1'b1;
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_BOUND;
          end
        end
      end
      ST_BOUND: begin
        if ((w_x_sum > c_wide) || (w_y_sum > c_high)) begin
          w_fin       = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_rd_addr   = bus.calc_blk_1;
          w_state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        w_occ_nxt = w_occ_acc;
        case (r_k)
          3'd1:    w_rd_addr = bus.calc_blk_2;
          3'd2:    w_rd_addr = bus.calc_blk_3;
          3'd3:    w_rd_addr = bus.calc_blk_4;
          default: w_rd_addr = '0;
        endcase
        if (r_k >= 3'd4) begin
          w_fin       = 1'b1;
          w_fin_ok    = !w_occ_acc;
          w_state_nxt = ST_DONE;
        end else begin
          w_k_nxt = r_k + 3'd1;
        end
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_landed    = (r_op == c_op_down) && !r_ok;
        w_game_over = (r_op == c_op_spawn) && !r_ok;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Committed state is updated on entry to DONE so consumers see it with done
    if (w_fin) begin
      w_ok_nxt = w_fin_ok;
      if (w_fin_ok) begin
        w_cur_piece_nxt = w_cand_piece_nxt;
        w_cur_x_nxt     = w_cand_x_nxt;
        w_cur_y_nxt     = w_cand_y_nxt;
        w_cur_rot_nxt   = w_cand_rot_nxt;
      end else if (w_op_nxt == c_op_spawn) begin
        w_cur_piece_nxt = EMPTY_BLOCK;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_op         <= '0;
      r_cand_piece <= '0;
      r_cand_x     <= '0;
      r_cand_y     <= '0;
      r_cand_rot   <= '0;
      r_k          <= '0;
      r_occ        <= 1'b0;
      r_ok         <= 1'b0;
      r_cur_piece  <= EMPTY_BLOCK;
      r_cur_x      <= '0;
      r_cur_y      <= '0;
      r_cur_rot    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_op         <= w_op_nxt;
      r_cand_piece <= w_cand_piece_nxt;
      r_cand_x     <= w_cand_x_nxt;
      r_cand_y     <= w_cand_y_nxt;
      r_cand_rot   <= w_cand_rot_nxt;
      r_k          <= w_k_nxt;
      r_occ        <= w_occ_nxt;
      r_ok         <= w_ok_nxt;
      r_cur_piece  <= w_cur_piece_nxt;
      r_cur_x      <= w_cur_x_nxt;
      r_cur_y      <= w_cur_y_nxt;
      r_cur_rot    <= w_cur_rot_nxt;
    end
  end

  assign bus.req_ready     = w_req_ready;
  assign bus.calc_piece    = r_cand_piece;
  assign bus.calc_x        = r_cand_x;
  assign bus.calc_y        = r_cand_y;
  assign bus.calc_rot      = r_cand_rot;
  assign bus.board_rd_addr = w_rd_addr;
  assign bus.cur_piece     = r_cur_piece;
  assign bus.cur_x         = r_cur_x;
  assign bus.cur_y         = r_cur_y;
  assign bus.cur_rot       = r_cur_rot;
  assign bus.done          = w_done;
  assign bus.ok            = w_done & r_ok;
  assign bus.landed        = w_landed;
  assign bus.game_over     = w_game_over;

endmodule
`default_nettype wire

// File: tb/tb_piece_move_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_piece_move_ctrl : directed bench with a rule-level move model     |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_piece_move_ctrl;
  localparam int W = 10;
  localparam int H = 20;
  localparam logic [2:0] OP_LEFT = 3'd0, OP_RIGHT = 3'd1, OP_ROT = 3'd2,
                         OP_DOWN = 3'd3, OP_SPAWN = 3'd4;
  localparam logic [2:0] P_EMPTY = 3'd0, P_I = 3'd1, P_O = 3'd2, P_T = 3'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic chk_en = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  piece_move_ctrl_if #(.BITS_PER_BLOCK(3)) bif ();

  piece_move_ctrl #(
    .BLOCKS_WIDE(10), .BLOCKS_HIGH(20), .SPAWN_X(4),
    .BITS_PER_BLOCK(3), .EMPTY_BLOCK(3'd0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shape table: {width[2:0], height[2:0], {dx,dy} x4}
  function automatic logic [21:0] shape(input int p, input int r);
    logic [1:0] rr;
    rr = r[1:0];
    case (p)
      1: return rr[0] ? {3'd4, 3'd1, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0}
                      : {3'd1, 3'd4, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3};
      2: return {3'd2, 3'd2, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
      default: case (rr)
        2'd0: return {3'd3, 3'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1};
        2'd1: return {3'd2, 3'd3, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd2};
        2'd2: return {3'd3, 3'd2, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd1};
        default: return {3'd2, 3'd3, 2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
      endcase
    endcase
  endfunction

  function automatic int cell_of(input int p, input int r, input int x, input int y, input int k);
    logic [21:0] s;
    s = shape(p, r);
    return (y + int'(s[13-4*k -: 2])) * W + x + int'(s[15-4*k -: 2]);
  endfunction

  // Combinational calculator the controller talks to
  logic [21:0] calc_shape;
  int          c0, c1, c2, c3;
  assign calc_shape = shape(int'(bif.calc_piece), int'(bif.calc_rot));
  assign c0 = cell_of(int'(bif.calc_piece), int'(bif.calc_rot), int'(bif.calc_x), int'(bif.calc_y), 0);
  assign c1 = cell_of(int'(bif.calc_piece), int'(bif.calc_rot), int'(bif.calc_x), int'(bif.calc_y), 1);
  assign c2 = cell_of(int'(bif.calc_piece), int'(bif.calc_rot), int'(bif.calc_x), int'(bif.calc_y), 2);
  assign c3 = cell_of(int'(bif.calc_piece), int'(bif.calc_rot), int'(bif.calc_x), int'(bif.calc_y), 3);
  assign bif.calc_blk_1  = c0[7:0];
  assign bif.calc_blk_2  = c1[7:0];
  assign bif.calc_blk_3  = c2[7:0];
  assign bif.calc_blk_4  = c3[7:0];
  assign bif.calc_width  = calc_shape[21:19];
  assign bif.calc_height = calc_shape[18:16];

  logic board_mem [256];
  always @(posedge clk) bif.board_rd_data <= board_mem[bif.board_rd_addr];

  // Model state: committed piece before/after the current request
  logic [2:0] m_old_p, m_new_p, cand_p;
  logic [3:0] m_old_x, m_new_x, cand_x;
  logic [4:0] m_old_y, m_new_y, cand_y;
  logic [1:0] m_old_r, m_new_r, cand_r;
  logic [7:0] cells [4];
  logic [2:0] e_resp;
  int         tx = -1000;
  int         lat = 0;
  int         kind = 0;
  int         last_done = -1;
  logic [2:0] last_resp = 3'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_old_p = P_EMPTY; m_old_x = 4'd0; m_old_y = 5'd0; m_old_r = 2'd0;
    m_new_p = P_EMPTY; m_new_x = 4'd0; m_new_y = 5'd0; m_new_r = 2'd0;
    tx = -1000; lat = 0; kind = 0; e_resp = 3'd0;
  endtask

  task automatic model_req(input logic [2:0] op, input logic [2:0] piece);
    int p, x, y, r, w, h, cl;
    logic [21:0] s;
    logic occ, okv;
    m_old_p = m_new_p; m_old_x = m_new_x; m_old_y = m_new_y; m_old_r = m_new_r;
    p = int'(m_new_p); x = int'(m_new_x); y = int'(m_new_y); r = int'(m_new_r);
    occ = 1'b0;
    if (op > OP_SPAWN || (op != OP_SPAWN && m_new_p == P_EMPTY) || (op == OP_LEFT && x == 0)) begin
      kind = 0;
    end else begin
      case (op)
        OP_LEFT:  x = x - 1;
        OP_RIGHT: x = x + 1;
        OP_ROT:   r = (r + 1) % 4;
        OP_DOWN:  y = y + 1;
        default: begin p = int'(piece); x = 4; y = 0; r = 0; end
      endcase
      s = shape(p, r);
      w = int'(s[21:19]);
      h = int'(s[18:16]);
      if (x + w > W || y + h > H) kind = 1;
      else begin
        kind = 2;
        for (int k = 0; k < 4; k++) begin
          cl = cell_of(p, r, x, y, k);
          cells[k] = cl[7:0];
          occ = occ | board_mem[cl[7:0]];
        end
      end
    end
    cand_p = p[2:0]; cand_x = x[3:0]; cand_y = y[4:0]; cand_r = r[1:0];
    okv = (kind == 2) && !occ;
    lat = (kind == 0) ? 0 : (kind == 1) ? 1 : 5;
    if (okv) begin
      m_new_p = cand_p; m_new_x = cand_x; m_new_y = cand_y; m_new_r = cand_r;
    end else if (op == OP_SPAWN) begin
      m_new_p = P_EMPTY;
    end
    e_resp = {okv, (op == OP_DOWN) && !okv, (op == OP_SPAWN) && !okv};
  endtask

  // Per-cycle comparison of every meaningful DUT output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      logic in_req, is_done;
      logic [7:0] ex_addr;
      in_req  = (cyc >= tx) && (cyc <= tx + lat);
      is_done = (cyc == tx + lat);
      chk("req_ready", 32'(bif.req_ready), 32'(!in_req));
      chk("done", 32'(bif.done), 32'(is_done));
      chk("resp", 32'({bif.ok, bif.landed, bif.game_over}), is_done ? 32'(e_resp) : 32'd0);
      if (cyc >= tx + lat)
        chk("cur", 32'({bif.cur_piece, bif.cur_x, bif.cur_y, bif.cur_rot}),
            32'({m_new_p, m_new_x, m_new_y, m_new_r}));
      else
        chk("cur", 32'({bif.cur_piece, bif.cur_x, bif.cur_y, bif.cur_rot}),
            32'({m_old_p, m_old_x, m_old_y, m_old_r}));
      ex_addr = 8'd0;
      if (kind == 2 && cyc >= tx && cyc <= tx + 3) ex_addr = cells[cyc - tx];
      chk("rd_addr", 32'(bif.board_rd_addr), 32'(ex_addr));
      if (kind != 0 && in_req)
        chk("calc", 32'({bif.calc_piece, bif.calc_x, bif.calc_y, bif.calc_rot}),
            32'({cand_p, cand_x, cand_y, cand_r}));
      if (bif.done) begin
        last_done = cyc;
        last_resp = {bif.ok, bif.landed, bif.game_over};
      end
    end
  end

  // Starts a request while the DUT is idle; returns one cycle into the request
  task automatic start_req(input logic [2:0] op, input logic [2:0] piece);
    bif.req_valid = 1'b1;
    bif.req_op    = op;
    bif.req_piece = piece;
    model_req(op, piece);
    tx = cyc + 1;
    @(posedge clk); #1;
    bif.req_valid = 1'b0;
  endtask

  task automatic do_req(input logic [2:0] op, input logic [2:0] piece);
    start_req(op, piece);
    repeat (lat) @(posedge clk);
    #1;
    @(posedge clk); #1;
  endtask

  initial begin
    int saved_tx;
    for (int i = 0; i < 256; i++) board_mem[i] = 1'b0;
    bif.req_valid = 1'b0;
    bif.req_op    = 3'd0;
    bif.req_piece = 3'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("lit_reset_cur", 32'({bif.cur_piece, bif.cur_x, bif.cur_y, bif.cur_rot}), 32'd0);
    chk("lit_reset_ready", 32'(bif.req_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // SPAWN T on an empty board
    do_req(OP_SPAWN, P_T);
    chk("lit_spawn_cells", {cells[0], cells[1], cells[2], cells[3]}, {8'd5, 8'd14, 8'd15, 8'd16});
    chk("lit_spawn_lat", 32'(last_done - tx), 32'd5);
    chk("lit_spawn_cur", 32'({bif.cur_piece, bif.cur_x, bif.cur_y, bif.cur_rot}),
        32'({3'd3, 4'd4, 5'd0, 2'd0}));

    // Walk to the left wall, then LEFT at x=0 is an immediate reject
    repeat (4) do_req(OP_LEFT, P_EMPTY);
    do_req(OP_LEFT, P_EMPTY);
    chk("lit_left_wall_lat", 32'(last_done - tx), 32'd0);
    chk("lit_left_wall_x", 32'(bif.cur_x), 32'd0);

    // Rotation through all four states, then an illegal opcode
    do_req(OP_RIGHT, P_EMPTY);
    repeat (4) do_req(OP_ROT, P_EMPTY);
    chk("lit_rot_wrap", 32'({bif.cur_x, bif.cur_rot}), 32'({4'd1, 2'd0}));
    do_req(3'd6, P_EMPTY);
    chk("lit_bad_op", 32'(last_resp), 32'd0);

    // Vertical I at x=8 cannot rotate flat (8+4 > 10)
    do_req(OP_SPAWN, P_I);
    repeat (4) do_req(OP_RIGHT, P_EMPTY);
    do_req(OP_ROT, P_EMPTY);
    chk("lit_i_rot_lat", 32'(last_done - tx), 32'd1);
    chk("lit_i_rot_cur", 32'({bif.cur_x, bif.cur_rot}), 32'({4'd8, 2'd0}));

    // O down to the floor: y=18 is the last legal row
    do_req(OP_SPAWN, P_O);
    repeat (18) do_req(OP_DOWN, P_EMPTY);
    do_req(OP_DOWN, P_EMPTY);
    chk("lit_floor_resp", 32'(last_resp), 32'b010);
    chk("lit_floor_y", 32'(bif.cur_y), 32'd18);

    // O at (4,10) lands on occupied cell 125
    do_req(OP_SPAWN, P_O);
    repeat (10) do_req(OP_DOWN, P_EMPTY);
    board_mem[125] = 1'b1;
    do_req(OP_DOWN, P_EMPTY);
    chk("lit_land_resp", 32'(last_resp), 32'b010);
    chk("lit_land_y", 32'(bif.cur_y), 32'd10);

    // Spawn onto occupied cell 5 ends the game
    board_mem[5] = 1'b1;
    do_req(OP_SPAWN, P_T);
    chk("lit_go_resp", 32'(last_resp), 32'b001);
    chk("lit_go_piece", 32'(bif.cur_piece), 32'd0);
    do_req(OP_LEFT, P_EMPTY);
    chk("lit_go_left_lat", 32'(last_done - tx), 32'd0);

    // Reset in the middle of the board reads aborts without done
    board_mem[5] = 1'b0;
    start_req(OP_SPAWN, P_T);
    saved_tx = tx;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    model_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("lit_abort_no_done", 32'(last_done < saved_tx), 32'd1);
    chk("lit_abort_cur", 32'({bif.cur_piece, bif.cur_x, bif.cur_y, bif.cur_rot}), 32'd0);

    do_req(OP_SPAWN, P_T);
    chk("lit_respawn_cur", 32'({bif.cur_piece, bif.cur_x}), 32'({3'd3, 4'd4}));

    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
